alu_bist_ctrl: RTL and testbench

- Hardware self-test sequencer for the ALU: the controlling end of the ALU operand/result interface.
- Walks a fixed vector table, drives A/B/ALUControl, waits for the result to settle, then compares Result and the masked flags against expected values.
- Reports pass/fail, the failure count and the index of the first failing vector.
- Sits beside the ALU in the datapath and is used for power-on test and in simulation.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_bist_rom.sv | 46 ++++
 rtl/alu_bist_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_bist_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag positions and self-test vector layout.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 4;
  localparam int IDX_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp_result;
    logic [FLAG_W-1:0] exp_flags;
    logic [FLAG_W-1:0] flag_mask;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } bist_state_e;

  // Only flags selected by the mask take part in the comparison.
  function automatic logic vec_mismatch(
    input logic [DATA_W-1:0] result,
    input logic [FLAG_W-1:0] flags,
    input vec_t              v
  );
    return (result != v.exp_result) ||
           (((flags ^ v.exp_flags) & v.flag_mask) != '0);
  endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed ALU self-test vector table, indexed combinationally.
module alu_bist_rom
  import alu_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] exp_result,
  output logic [FLAG_W-1:0] exp_flags,
  output logic [FLAG_W-1:0] flag_mask
);

  vec_t v;

  always_comb begin
    v = '0;
    unique case (idx)
      3'd0: v = '{OP_ADD, 32'd5, 32'd7, 32'd12,
                  4'b0000, 4'b1111};
      3'd1: v = '{OP_SUB, 32'd10, 32'd3, 32'd7,
                  4'b0000, 4'b1101};
      3'd2: v = '{OP_AND, 32'hFF00FF00, 32'h0F0F0F0F,
                  32'h0F000F00, 4'b0000, 4'b0100};
      3'd3: v = '{OP_OR, 32'hFF00FF00, 32'h0F0F0F0F,
                  32'hFF0FFF0F, 4'b0000, 4'b0100};
      3'd4: v = '{OP_SLT, 32'hFFFFFFFB, 32'd10, 32'd1,
                  4'b0000, 4'b0100};
      3'd5: v = '{OP_SUB, 32'd10, 32'd10, 32'd0,
                  4'b0100, 4'b1101};
      3'd6: v = '{OP_ADD, 32'h7FFFFFFF, 32'd1,
                  32'h80000000, 4'b1001, 4'b1111};
      3'd7: v = '{OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0,
                  4'b0110, 4'b1111};
      default: v = '0;
    endcase
  end

  assign op         = v.op;
  assign a          = v.a;
  assign b          = v.b;
  assign exp_result = v.exp_result;
  assign exp_flags  = v.exp_flags;
  assign flag_mask  = v.flag_mask;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU self-test sequencer: applies ROM vectors, checks results,
// and reports pass/fail, failure count and first failing index.
module alu_bist_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_VECTORS = 8,
  parameter int ALU_LAT     = 0,
  parameter int FC_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic [OP_W-1:0]     ALUControl,
  input  logic [DATA_W-1:0]   Result,
  input  logic                OverFlow,
  input  logic                Carry,
  input  logic                Zero,
  input  logic                Negative,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [FC_W-1:0]     fail_count,
  output logic [IDX_W-1:0]    first_fail_idx
);

  localparam int WC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_VECTORS - 1);

  bist_state_e       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WC_W-1:0]   wcnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [FC_W-1:0]   fc_q;
  logic [IDX_W-1:0]  ff_q;

  vec_t              rom_v;
  logic [FLAG_W-1:0] flags;
  logic              mismatch;

  alu_bist_rom u_rom (
    .idx        (idx_q),
    .op         (rom_v.op),
    .a          (rom_v.a),
    .b          (rom_v.b),
    .exp_result (rom_v.exp_result),
    .exp_flags  (rom_v.exp_flags),
    .flag_mask  (rom_v.flag_mask)
  );

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = Negative;
    flags[FLAG_Z] = Zero;
    flags[FLAG_C] = Carry;
    flags[FLAG_V] = OverFlow;
    mismatch      = vec_mismatch(Result, flags, rom_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= '0;
      ff_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_q   <= '0;
            fc_q    <= '0;
            ff_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          a_q     <= rom_v.a;
          b_q     <= rom_v.b;
          op_q    <= rom_v.op;
          wcnt_q  <= '0;
          state_q <= (ALU_LAT > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q + WC_W'(1);
          if (wcnt_q == WC_LAST) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            fc_q <= fc_q + FC_W'(1);
            if (fc_q == '0) ff_q <= idx_q;
          end
          // pass folds in this vector's outcome, not yet in fc_q
          if (idx_q == IDX_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fc_q == '0) && !mismatch;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_APPLY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign ALUControl     = op_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fc_q;
  assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Randomized bench: behavioural ALU with injectable faults,
// expected BIST outcome derived from the vector table.
module tb_alu_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;

  logic [31:0] a0, b0, res0;
  logic [2:0]  op0, ff0;
  logic        v0, c0, z0, n0;
  logic        busy0, done0, pass0;
  logic [3:0]  fc0;

  logic [31:0] a1, b1, res1;
  logic [2:0]  op1, ff1;
  logic        v1, c1, z1, n1;
  logic        busy1, done1, pass1;
  logic [3:0]  fc1;

  bit          and_as_or, carry_lo, dly_sel;
  bit [7:0]    bad_set;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  t_op [8];
  logic [31:0] t_a  [8];
  logic [31:0] t_b  [8];
  logic [31:0] t_r  [8];
  logic [3:0]  t_f  [8];
  logic [3:0]  t_m  [8];

  initial begin
    t_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd0, 3'd0};
    t_a  = '{32'd5, 32'd10, 32'hFF00FF00, 32'hFF00FF00,
             32'hFFFFFFFB, 32'd10, 32'h7FFFFFFF, 32'hFFFFFFFF};
    t_b  = '{32'd7, 32'd3, 32'h0F0F0F0F, 32'h0F0F0F0F,
             32'd10, 32'd10, 32'd1, 32'd1};
    t_r  = '{32'd12, 32'd7, 32'h0F000F00, 32'hFF0FFF0F,
             32'd1, 32'd0, 32'h80000000, 32'd0};
    t_f  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
             4'b0000, 4'b0100, 4'b1001, 4'b0110};
    t_m  = '{4'b1111, 4'b1101, 4'b0100, 4'b0100,
             4'b0100, 4'b1101, 4'b1111, 4'b1111};
  end

  // Returns {N,Z,C,V,result}; faults select a broken ALU.
  function automatic logic [35:0] alu_f(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] op, input bit aor, input bit clo,
    input bit [7:0] bs
  );
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = aor ? (a | b) : (a & b);
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    if (clo) c = 1'b0;
    for (int k = 0; k < 8; k++)
      if (bs[k] && op == t_op[k] && a == t_a[k] && b == t_b[k])
        r = r ^ 32'h1;
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  logic [35:0] d0_1, d0_2, d1_1, d1_2, now0;

  always @(posedge clk) begin
    d0_1 <= alu_f(a0, b0, op0, and_as_or, carry_lo, bad_set);
    d0_2 <= d0_1;
    d1_1 <= alu_f(a1, b1, op1, and_as_or, carry_lo, bad_set);
    d1_2 <= d1_1;
  end

  always_comb begin
    now0 = alu_f(a0, b0, op0, and_as_or, carry_lo, bad_set);
    if (dly_sel) now0 = d0_2;
  end

  assign {n0, z0, c0, v0, res0} = now0;
  assign {n1, z1, c1, v1, res1} = d1_2;

  alu_bist_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .A(a0), .B(b0), .ALUControl(op0),
    .Result(res0), .OverFlow(v0), .Carry(c0),
    .Zero(z0), .Negative(n0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_idx(ff0)
  );

  alu_bist_ctrl #(.ALU_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .A(a1), .B(b1), .ALUControl(op1),
    .Result(res1), .OverFlow(v1), .Carry(c1),
    .Zero(z1), .Negative(n1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_idx(ff1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_run(output int efc, output int efirst);
    logic [35:0] o;
    bit mm;
    efc = 0; efirst = 0;
    for (int k = 0; k < 8; k++) begin
      o = alu_f(t_a[k], t_b[k], t_op[k], and_as_or, carry_lo, bad_set);
      mm = (o[31:0] != t_r[k]) ||
           (((o[35:32] ^ t_f[k]) & t_m[k]) != 4'b0);
      if (mm) begin
        if (efc == 0) efirst = k;
        efc++;
      end
    end
  endtask

  task automatic run0(input int repulse, output int lat);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("cleared_fc", fc0, 0);
    chk("cleared_done", done0, 0);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (n == repulse) start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      if (n == 1) chk("busy_run", busy0, 1);
      if (done0) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic full0(input string tag, input int repulse);
    int lat, efc, efirst;
    expect_run(efc, efirst);
    run0(repulse, lat);
    chk({tag, "_lat"}, lat, 16);
    chk({tag, "_pass"}, pass0, efc == 0);
    chk({tag, "_fc"}, fc0, efc);
    if (efc != 0) chk({tag, "_first"}, ff0, efirst);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_Ahold"}, {op0, a0, b0[0]}, {3'd0, 32'hFFFFFFFF, 1'b1});
  endtask

  task automatic full1(input string tag);
    int lat, efc, efirst;
    expect_run(efc, efirst);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done1) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 32);
    chk({tag, "_pass"}, pass1, efc == 0);
    chk({tag, "_fc"}, fc1, efc);
    if (efc != 0) chk({tag, "_first"}, ff1, efirst);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    and_as_or = 0; carry_lo = 0; bad_set = '0; dly_sel = 0;
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_fc", fc0, 0);
    chk("rst_A", a0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    full0("clean", 0);
    and_as_or = 1;
    full0("and_or", 0);
    chk("and_or_first2", ff0, 3'd2);
    and_as_or = 0; carry_lo = 1;
    full0("carry0", 0);
    chk("carry0_fc1", fc0, 4'd1);
    carry_lo = 0;
    full0("restart_clean", 7);

    bad_set = 8'h01;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_fc", fc0, 0);
    chk("midrst_A", a0, 0);
    chk("midrst_done", done0, 0);
    @(posedge clk); #1 rst = 1'b0;
    bad_set = '0;
    full0("post_rst", 0);

    dly_sel = 1;
    run0(0, lat);
    chk("dly_lat0_pass", pass0, 0);
    dly_sel = 0;
    full1("lat2_clean");
    bad_set = 8'h24;
    full1("lat2_bad");
    bad_set = '0;

    for (int it = 0; it < 12; it++) begin
      and_as_or = 1'($urandom_range(0, 1));
      carry_lo  = 1'($urandom_range(0, 1));
      bad_set   = 8'($urandom);
      full0("rand", ($urandom_range(0, 1) == 1) ?
                    int'($urandom_range(2, 15)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
